// File: rtl/led_matrix_scan_ctrl.sv
// LED matrix row scanner: programs an interval timer over a simple write port,
// advances one row per timer interrupt. Optional LEDMTX_BLANK_EN adds dead time between rows.
module led_matrix_scan_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  input  logic [31:0]     period_in,
  input  logic            fb_wr_en,
  input  logic [RW-1:0]   fb_wr_addr,
  input  logic [COLS-1:0] fb_wr_data,
  input  logic            timer_irq,
  output logic [2:0]      avm_address,
  output logic            avm_chipselect,
  output logic            avm_write_n,
  output logic [15:0]     avm_writedata,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, ACK, STOP_CTL, STOP_ACK
  } state_t;

  state_t          state, next;
  logic [31:0]     period;
  logic [RW-1:0]   row_idx;
  logic [COLS-1:0] fb [ROWS];
  logic            accept, advance, drive;

  assign accept  = (state == IDLE) && start && !stop;
  assign advance = (state == RUN) && timer_irq && !stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:     if (accept) next = WR_PL;
      WR_PL:    next = stop ? STOP_CTL : WR_PH;
      WR_PH:    next = stop ? STOP_CTL : WR_CTRL;
      WR_CTRL:  next = stop ? STOP_CTL : RUN;
      RUN:      next = stop ? STOP_CTL : (timer_irq ? ACK : RUN);
      ACK:      next = stop ? STOP_CTL : RUN;
      STOP_CTL: next = STOP_ACK;
      STOP_ACK: next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    case (state)
      WR_PL:    begin avm_address = 3'd2; avm_writedata = period[15:0];  end
      WR_PH:    begin avm_address = 3'd3; avm_writedata = period[31:16]; end
      WR_CTRL:  begin avm_address = 3'd1; avm_writedata = 16'h0007;      end
      ACK:      begin avm_address = 3'd0; avm_writedata = 16'h0000;      end
      STOP_CTL: begin avm_address = 3'd1; avm_writedata = 16'h0008;      end
      STOP_ACK: begin avm_address = 3'd0; avm_writedata = 16'h0000;      end
      default:  ;
    endcase
    if (state inside {WR_PL, WR_PH, WR_CTRL, ACK, STOP_CTL, STOP_ACK}) begin
      avm_chipselect = 1'b1;
      avm_write_n    = 1'b0;
    end
  end

  assign busy       = (state != IDLE);
  // Index advances on entry to ACK, so ACK with index 0 is the wrap cycle.
  assign frame_done = (state == ACK) && (row_idx == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= '0;
      row_idx <= '0;
    end else if (accept) begin
      period  <= period_in;
      row_idx <= '0;
    end else if (advance) begin
      row_idx <= (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) fb[r] <= '0;
    end else if (fb_wr_en && ({1'b0, fb_wr_addr} < (RW+1)'(ROWS))) begin
      fb[fb_wr_addr] <= fb_wr_data;
    end
  end

`ifdef LEDMTX_BLANK_EN
  assign drive = (state == RUN);
`else
  assign drive = (state == RUN) || (state == ACK);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_n <= '1;
      col   <= '0;
    end else if (drive) begin
      row_n <= ~(ROWS'(1) << row_idx);
      col   <= fb[row_idx];
    end else begin
      row_n <= '1;
      col   <= '0;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl (8x8): timer programming, row scan,
// frame buffer update latency, stop handling and mid-sequence reset.
module tb_led_matrix_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, fb_wr_en, timer_irq;
  logic [31:0] period_in;
  logic [2:0]  fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic [7:0]  row_n, col;
  logic        busy, frame_done;

  int n_chk = 0;
  int n_fail = 0;
  int er = 0;
  logic [7:0] fbm [8];

  always #5 clk = ~clk;

  led_matrix_scan_ctrl #(.ROWS(8), .COLS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .period_in(period_in), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .timer_irq(timer_irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .row_n(row_n), .col(col), .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    check({tag, " cs"}, {31'd0, avm_chipselect}, 32'd1);
    check({tag, " wn"}, {31'd0, avm_write_n}, 32'd0);
    check({tag, " addr"}, {29'd0, avm_address}, {29'd0, a});
    check({tag, " data"}, {16'd0, avm_writedata}, {16'd0, d});
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, " cs"}, {31'd0, avm_chipselect}, 32'd0);
    check({tag, " wn"}, {31'd0, avm_write_n}, 32'd1);
    check({tag, " addr"}, {29'd0, avm_address}, 32'd0);
    check({tag, " data"}, {16'd0, avm_writedata}, 32'd0);
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] r, input logic [7:0] c);
    check({tag, " row_n"}, {24'd0, row_n}, {24'd0, r});
    check({tag, " col"}, {24'd0, col}, {24'd0, c});
  endtask

  task automatic do_start(input logic [31:0] p);
    start = 1'b1; period_in = p;
    step();
    start = 1'b0;
    check("start busy", {31'd0, busy}, 32'd1);
    chk_wr("wr_pl", 3'd2, p[15:0]);
    step(); chk_wr("wr_ph", 3'd3, p[31:16]);
    step(); chk_wr("wr_ctrl", 3'd1, 16'h0007);
    step(); chk_quiet("run0");
    step(); chk_disp("run0 disp", 8'hFE, fbm[0]);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; fb_wr_en = 1'b0; timer_irq = 1'b0;
    period_in = '0; fb_wr_addr = '0; fb_wr_data = '0;
    fbm = '{8'h81, 8'h42, 8'h24, 8'hA5, 8'h18, 8'h00, 8'hFF, 8'h7E};
    step(); step();
    chk_quiet("reset");
    chk_disp("reset", 8'hFF, 8'h00);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;
    step();

    // stop in IDLE has no effect
    stop = 1'b1; step(); stop = 1'b0;
    check("idle stop busy", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 8; r++) begin
      fb_wr_en = 1'b1; fb_wr_addr = 3'(r); fb_wr_data = fbm[r];
      step();
    end
    fb_wr_en = 1'b0;

    do_start(32'h0001_86A0);

    // one irq per 10 clocks; 11 irqs wrap once and land on row 3
    for (int k = 0; k < 11; k++) begin
      timer_irq = 1'b1;
      step();
      timer_irq = 1'b0;
      chk_wr("ack", 3'd0, 16'h0000);
      chk_disp("ack hold", ~(8'h01 << er), fbm[er]);
      check("ack frame_done", {31'd0, frame_done}, {31'd0, (er == 7)});
      er = (er + 1) % 8;
      step();
      chk_quiet("post ack");
      check("post ack frame_done", {31'd0, frame_done}, 32'd0);
`ifdef LEDMTX_BLANK_EN
      chk_disp("blank", 8'hFF, 8'h00);
`else
      chk_disp("new row", ~(8'h01 << er), fbm[er]);
`endif
      step();
      chk_disp("row settled", ~(8'h01 << er), fbm[er]);
      repeat (7) step();
    end
    check("row idx", {24'd0, row_n}, 32'h0000_00F7);

    // rewrite the displayed row
    fb_wr_en = 1'b1; fb_wr_addr = 3'd3; fb_wr_data = 8'h3C;
    step();
    fb_wr_en = 1'b0;
    check("rewrite +1", {24'd0, col}, 32'h0000_00A5);
    step();
    check("rewrite +2", {24'd0, col}, 32'h0000_003C);
    fbm[3] = 8'h3C;

    // stop beats irq
    stop = 1'b1; timer_irq = 1'b1;
    step();
    stop = 1'b0; timer_irq = 1'b0;
    chk_wr("stop_ctl", 3'd1, 16'h0008);
    check("stop_ctl frame_done", {31'd0, frame_done}, 32'd0);
    chk_disp("stop_ctl disp", 8'hF7, 8'h3C);
    step(); chk_wr("stop_ack", 3'd0, 16'h0000);
    step(); chk_quiet("stopped");
    chk_disp("stopped", 8'hFF, 8'h00);
    check("stopped busy", {31'd0, busy}, 32'd0);

    // reset asserted during WR_PH
    start = 1'b1; period_in = 32'h1234_5678;
    step(); start = 1'b0;
    chk_wr("r wr_pl", 3'd2, 16'h5678);
    step(); chk_wr("r wr_ph", 3'd3, 16'h1234);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async reset");
    check("async reset busy", {31'd0, busy}, 32'd0);
    #2 reset_n = 1'b1;
    step();
    check("after reset busy", {31'd0, busy}, 32'd0);
    for (int r = 0; r < 8; r++) fbm[r] = 8'h00;
    do_start(32'h0000_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
